mul_rr_arbiter: RTL and testbench

- Shares one pipelined 8x8 multiplier among NREQ requesters. The multiplier registers its operands and its product, so it has 2 clock edges of latency.
- Round-robin arbitration, one operation issued per cycle, valid/ready request handshake.
- Carries a requester-ID tag alongside the multiplier pipeline, so every product returns with the ID of the requester that issued it.
- Sits between the multiplier's operand/product ports and the client blocks that need multiplies.

---
 rtl/mul_rr_arbiter.sv | 109 ++++++++++
 tb/tb_mul_rr_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_rr_arbiter.sv
// Round-robin front end that shares one pipelined 8x8 multiplier among NREQ
// requesters and tags every product with the ID of the requester that issued it.
module mul_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_p,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_p,
  output logic [2:0]        inflight
);

  if (NREQ < 2 || NREQ > 8 || NREQ > (1 << IDW) || MUL_LAT < 1 || MUL_LAT > 7)
  begin : g_bad_cfg
    $error("mul_rr_arbiter: illegal NREQ/IDW/MUL_LAT combination");
  end

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [MUL_LAT-1:0] tag_v_q, tag_v_d;
  logic [IDW-1:0]     tag_id_q [MUL_LAT];
  logic [IDW-1:0]     tag_id_d [MUL_LAT];
  logic [2:0]         inflight_q, inflight_d;

  logic [NREQ-1:0]    grant;
  logic               grant_any;
  logic [IDW-1:0]     grant_idx;
  logic [7:0]         op_a, op_b;
  logic               retire;

  // Handshake: request i transfers on a cycle where req_valid[i] && req_ready[i].
  // req_ready is a pure function of req_valid and ptr_q (never of a transfer),
  // at most one bit is set, and it is held low while rst is high.
  always_comb begin : arb
    int pos;
    pos       = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    op_a      = '0;
    op_b      = '0;
    ptr_d     = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!rst && !grant_any && pos == i && req_valid[i]) begin
          grant_any = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = IDW'(i);
          op_a      = req_a[8*i +: 8];
          op_b      = req_b[8*i +: 8];
          ptr_d     = (i == NREQ - 1) ? '0 : IDW'(i + 1);
        end
      end
    end
  end

  assign retire = tag_v_q[MUL_LAT-1];

  // The tag pipe mirrors the multiplier's operand and product registers.
  always_comb begin : tag_next
    tag_v_d     = '0;
    tag_v_d[0]  = grant_any;
    tag_id_d[0] = grant_idx;
    for (int s = 1; s < MUL_LAT; s++) begin
      tag_v_d[s]  = tag_v_q[s-1];
      tag_id_d[s] = tag_id_q[s-1];
    end
    case ({grant_any, retire})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      tag_v_q    <= '0;
      inflight_q <= '0;
      for (int s = 0; s < MUL_LAT; s++) tag_id_q[s] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      tag_v_q    <= tag_v_d;
      inflight_q <= inflight_d;
      for (int s = 0; s < MUL_LAT; s++) tag_id_q[s] <= tag_id_d[s];
    end
  end

  assign req_ready = grant;
  assign mul_a     = op_a;
  assign mul_b     = op_b;
  assign rsp_valid = retire;
  assign rsp_id    = tag_id_q[MUL_LAT-1];
  // Untagged products (idle slots, stale data after reset) never reach clients.
  assign rsp_p     = retire ? mul_p : 16'd0;
  assign inflight  = inflight_q;

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Directed bench for mul_rr_arbiter with a two-register multiplier model
// standing in for the shared multiplier.
module tb_mul_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_p;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_p;
  logic [2:0]  inflight;

  logic [7:0]  ma_q, mb_q;
  int          total_cnt;
  int          bad_cnt;

  mul_rr_arbiter #(.NREQ(4), .IDW(2), .MUL_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .inflight  (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared multiplier: operands registered, then product registered.
  always @(posedge clk) begin
    ma_q  <= mul_a;
    mb_q  <= mul_b;
    mul_p <= 16'(ma_q) * 16'(mb_q);
  end

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; req_a = 32'h04030201; req_b = 32'h01010101;
    @(negedge clk); #1;
    total_cnt++;
    if (req_ready !== 4'b0000) begin bad_cnt++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    @(negedge clk); rst = 1'b0; req_valid = 4'h0; #1;
    total_cnt++;
    if (rsp_valid !== 1'b0) begin bad_cnt++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total_cnt++;
    if (rsp_id !== 2'd0) begin bad_cnt++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    total_cnt++;
    if (rsp_p !== 16'd0) begin bad_cnt++; $display("FAIL reset_rsp_p got=%0d exp=0", rsp_p); end
    total_cnt++;
    if (inflight !== 3'd0) begin bad_cnt++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_rdy;
    logic        exp_v;
    logic [15:0] exp_p;
    logic [2:0]  exp_inf;
    req_a = {8'd4, 8'd3, 8'd2, 8'd1};
    req_b = {4{8'd255}};
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      exp_rdy = (k < 8) ? 4'(1 << (k % 4)) : 4'h0;
      exp_v   = (k >= 2 && k < 10);
      exp_p   = exp_v ? 16'(((k - 2) % 4 + 1) * 255) : 16'd0;
      exp_inf = (k == 0) ? 3'd0 : (k == 1) ? 3'd1 : (k <= 8) ? 3'd2 : (k == 9) ? 3'd1 : 3'd0;
      total_cnt++;
      if (req_ready !== exp_rdy) begin bad_cnt++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, exp_rdy); end
      if (k < 8) begin
        total_cnt++;
        if (mul_a !== 8'(k % 4 + 1)) begin bad_cnt++; $display("FAIL rr_mul_a k=%0d got=%0d exp=%0d", k, mul_a, k % 4 + 1); end
      end
      total_cnt++;
      if (rsp_valid !== exp_v) begin bad_cnt++; $display("FAIL rr_rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, exp_v); end
      total_cnt++;
      if (rsp_p !== exp_p) begin bad_cnt++; $display("FAIL rr_rsp_p k=%0d got=%0d exp=%0d", k, rsp_p, exp_p); end
      if (exp_v) begin
        total_cnt++;
        if (rsp_id !== 2'((k - 2) % 4)) begin bad_cnt++; $display("FAIL rr_rsp_id k=%0d got=%0d exp=%0d", k, rsp_id, (k - 2) % 4); end
      end
      total_cnt++;
      if (inflight !== exp_inf) begin bad_cnt++; $display("FAIL rr_inflight k=%0d got=%0d exp=%0d", k, inflight, exp_inf); end
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 4'b0001; req_a = {24'd0, 8'd12}; req_b = {24'd0, 8'd10}; #1;
    total_cnt++;
    if (req_ready !== 4'b0001) begin bad_cnt++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    total_cnt++;
    if (mul_a !== 8'd12 || mul_b !== 8'd10) begin bad_cnt++; $display("FAIL single_operands got=%0d,%0d exp=12,10", mul_a, mul_b); end
    total_cnt++;
    if (inflight !== 3'd0) begin bad_cnt++; $display("FAIL single_inflight0 got=%0d exp=0", inflight); end
    @(negedge clk); req_valid = 4'h0; #1;
    total_cnt++;
    if (inflight !== 3'd1 || rsp_valid !== 1'b0) begin bad_cnt++; $display("FAIL single_c1 got=inf%0d,v%b exp=inf1,v0", inflight, rsp_valid); end
    @(negedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 16'd120) begin
      bad_cnt++; $display("FAIL single_rsp got=v%b,id%0d,p%0d exp=v1,id0,p120", rsp_valid, rsp_id, rsp_p);
    end
    total_cnt++;
    if (inflight !== 3'd1) begin bad_cnt++; $display("FAIL single_inflight2 got=%0d exp=1", inflight); end
    @(negedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b0 || rsp_p !== 16'd0 || inflight !== 3'd0) begin
      bad_cnt++; $display("FAIL single_c3 got=v%b,p%0d,inf%0d exp=v0,p0,inf0", rsp_valid, rsp_p, inflight);
    end
  endtask

  task automatic test_max_operands();
    @(negedge clk);
    req_valid = 4'b0100; req_a = 32'h00FF0000; req_b = 32'h00FF0000; #1;
    total_cnt++;
    if (req_ready !== 4'b0100 || mul_a !== 8'hFF || mul_b !== 8'hFF) begin
      bad_cnt++; $display("FAIL max_grant got=%b,%h,%h exp=0100,ff,ff", req_ready, mul_a, mul_b);
    end
    @(negedge clk); req_valid = 4'h0; #1;
    @(negedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_p !== 16'hFE01) begin
      bad_cnt++; $display("FAIL max_rsp got=v%b,id%0d,p%h exp=v1,id2,pfe01", rsp_valid, rsp_id, rsp_p);
    end
  endtask

  task automatic test_ptr_wrap();
    @(negedge clk);
    req_valid = 4'b1001; req_a = {8'd3, 8'd0, 8'd0, 8'd7}; req_b = {8'd5, 8'd0, 8'd0, 8'd9}; #1;
    total_cnt++;
    if (req_ready !== 4'b1000 || mul_a !== 8'd3) begin bad_cnt++; $display("FAIL wrap_first got=%b,%0d exp=1000,3", req_ready, mul_a); end
    @(negedge clk); #1;
    total_cnt++;
    if (req_ready !== 4'b0001 || mul_a !== 8'd7) begin bad_cnt++; $display("FAIL wrap_second got=%b,%0d exp=0001,7", req_ready, mul_a); end
    @(negedge clk); req_valid = 4'h0; #1;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_p !== 16'd15) begin
      bad_cnt++; $display("FAIL wrap_rsp3 got=v%b,id%0d,p%0d exp=v1,id3,p15", rsp_valid, rsp_id, rsp_p);
    end
    @(negedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 16'd63) begin
      bad_cnt++; $display("FAIL wrap_rsp0 got=v%b,id%0d,p%0d exp=v1,id0,p63", rsp_valid, rsp_id, rsp_p);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_drop();
    @(negedge clk);
    req_valid = 4'b0110; req_a = {8'd0, 8'd9, 8'd2, 8'd0}; req_b = {8'd0, 8'd9, 8'd3, 8'd0}; #1;
    total_cnt++;
    if (req_ready !== 4'b0010 || mul_a !== 8'd2) begin bad_cnt++; $display("FAIL drop_first got=%b,%0d exp=0010,2", req_ready, mul_a); end
    @(negedge clk); req_valid = 4'b0000; #1;
    total_cnt++;
    if (req_ready !== 4'b0000 || mul_a !== 8'd0 || mul_b !== 8'd0) begin
      bad_cnt++; $display("FAIL drop_idle got=%b,%0d,%0d exp=0000,0,0", req_ready, mul_a, mul_b);
    end
    @(negedge clk);
    req_valid = 4'b1001; req_a = {8'd4, 8'd0, 8'd0, 8'd1}; req_b = {8'd4, 8'd0, 8'd0, 8'd1}; #1;
    total_cnt++;
    if (req_ready !== 4'b1000) begin bad_cnt++; $display("FAIL drop_ptr got=%b exp=1000", req_ready); end
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_p !== 16'd6) begin
      bad_cnt++; $display("FAIL drop_rsp1 got=v%b,id%0d,p%0d exp=v1,id1,p6", rsp_valid, rsp_id, rsp_p);
    end
    @(negedge clk); req_valid = 4'h0; #1;
    total_cnt++;
    if (rsp_valid !== 1'b0 || rsp_p !== 16'd0) begin bad_cnt++; $display("FAIL drop_gap got=v%b,p%0d exp=v0,p0", rsp_valid, rsp_p); end
    @(negedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_p !== 16'd16) begin
      bad_cnt++; $display("FAIL drop_rsp3 got=v%b,id%0d,p%0d exp=v1,id3,p16", rsp_valid, rsp_id, rsp_p);
    end
  endtask

  task automatic test_idle();
    req_a = 32'h04030201; req_b = 32'h0A0A0A0A;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); req_valid = 4'h0; #1;
      total_cnt++;
      if (req_ready !== 4'h0 || mul_a !== 8'd0 || mul_b !== 8'd0 || rsp_valid !== 1'b0 || rsp_p !== 16'd0) begin
        bad_cnt++;
        $display("FAIL idle k=%0d got=rdy%b,a%0d,b%0d,v%b,p%0d exp=rdy0000,a0,b0,v0,p0", k, req_ready, mul_a, mul_b, rsp_valid, rsp_p);
      end
    end
    @(negedge clk); req_valid = 4'hF; #1;
    total_cnt++;
    if (req_ready !== 4'b0001) begin bad_cnt++; $display("FAIL idle_ptr got=%b exp=0001", req_ready); end
    @(negedge clk); req_valid = 4'h0; #1;
    @(negedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 16'd10) begin
      bad_cnt++; $display("FAIL idle_rsp got=v%b,id%0d,p%0d exp=v1,id0,p10", rsp_valid, rsp_id, rsp_p);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 4'b0011; req_a = {8'd0, 8'd0, 8'd6, 8'd5}; req_b = {8'd0, 8'd0, 8'd6, 8'd5}; #1;
    total_cnt++;
    if (req_ready !== 4'b0010) begin bad_cnt++; $display("FAIL rstmid_g1 got=%b exp=0010", req_ready); end
    @(negedge clk); req_valid = 4'b0001; #1;
    total_cnt++;
    if (req_ready !== 4'b0001 || inflight !== 3'd1) begin bad_cnt++; $display("FAIL rstmid_g0 got=%b,inf%0d exp=0001,inf1", req_ready, inflight); end
    @(negedge clk); rst = 1'b1; req_valid = 4'hF; #1;
    total_cnt++;
    if (req_ready !== 4'b0000 || inflight !== 3'd2) begin bad_cnt++; $display("FAIL rstmid_hold got=%b,inf%0d exp=0000,inf2", req_ready, inflight); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); rst = 1'b0; req_valid = 4'h0; #1;
      total_cnt++;
      if (rsp_valid !== 1'b0 || rsp_p !== 16'd0 || inflight !== 3'd0) begin
        bad_cnt++; $display("FAIL rstmid_flush k=%0d got=v%b,p%0d,inf%0d exp=v0,p0,inf0", k, rsp_valid, rsp_p, inflight);
      end
    end
    @(negedge clk);
    req_valid = 4'hF; req_a = {8'd1, 8'd1, 8'd1, 8'd11}; req_b = {8'd1, 8'd1, 8'd1, 8'd13}; #1;
    total_cnt++;
    if (req_ready !== 4'b0001 || mul_a !== 8'd11) begin bad_cnt++; $display("FAIL rstmid_ptr got=%b,%0d exp=0001,11", req_ready, mul_a); end
    @(negedge clk); req_valid = 4'h0; #1;
    @(negedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 16'd143) begin
      bad_cnt++; $display("FAIL rstmid_rsp got=v%b,id%0d,p%0d exp=v1,id0,p143", rsp_valid, rsp_id, rsp_p);
    end
    @(negedge clk); #1;
    total_cnt++;
    if (inflight !== 3'd0 || rsp_valid !== 1'b0) begin bad_cnt++; $display("FAIL rstmid_end got=inf%0d,v%b exp=inf0,v0", inflight, rsp_valid); end
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst       = 1'b1;
    req_valid = 4'h0;
    req_a     = '0;
    req_b     = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_max_operands();
    test_ptr_wrap();
    test_drop();
    test_idle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
